// File: rtl/menu_ctrl_pkg.sv
// Shared definitions for the game menu controller: FSM state encoding,
// mode count/width and the wrap-around mode step helper.
package menu_ctrl_pkg;

  localparam int NUM_MODES = 8;
  // Width of the mode field (3 bits for 8 modes).
  localparam int MODE_W = $clog2(NUM_MODES);

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Step the mode one position up or down.  Relies on the natural wrap of
  // the MODE_W-bit field (7 + 1 -> 0, 0 - 1 -> 7).
  function automatic logic [MODE_W-1:0] mode_step(input logic [MODE_W-1:0] i_mode,
                                                  input logic i_up);
    logic [MODE_W-1:0] v_next;
    if (i_up) begin
      v_next = i_mode + MODE_W'(1);
    end else begin
      v_next = i_mode - MODE_W'(1);
    end
    return v_next;
  endfunction

endpackage

// File: rtl/menu_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and rising-edge press
// event for one raw mechanical button.  The debounced level only follows the
// synchronized input after DEB_CYCLES consecutive samples that differ from
// the current level; any sample equal to the current level restarts the count.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_flip;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Decide whether this sample completes a stable run of opposite samples.
  always_comb begin
    w_differ = (r_sync2 != r_level);
    w_flip   = w_differ && (r_cnt == CNT_LAST);
  end

  // Count stable samples, update the debounced level and flag 0->1 flips.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else if (!w_differ) begin
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (w_flip) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
      r_press <= r_sync2;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_press <= 1'b0;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: game menu controller.  Three debounced buttons move through
// the MENU -> PLAY -> OVER -> MENU cycle and pick one of eight game modes.
// Optional feature macro: MENU_AUTOREPEAT_EN -- when defined, holding up or
// down in MENU repeats the step every REPEAT_CYCLES; when undefined each
// press gives exactly one step and no repeat timers exist.
module menu_ctrl
  import menu_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_sel,
  input  logic              game_over,
  output logic [MODE_W-1:0] mode,
  output logic              in_menu,
  output logic              playing,
  output logic              game_start
);

  logic w_up_lvl;
  logic w_up_press;
  logic w_dn_lvl;
  logic w_dn_press;
  logic w_sel_lvl;
  logic w_sel_press;
  logic w_up_evt;
  logic w_dn_evt;
  logic w_unused;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] w_mode_nxt;
  logic              r_in_menu;
  logic              r_playing;
  logic              r_game_start;
  logic              w_start_nxt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_up),
    .o_level (w_up_lvl),
    .o_press (w_up_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_down),
    .o_level (w_dn_lvl),
    .o_press (w_dn_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_sel),
    .o_level (w_sel_lvl),
    .o_press (w_sel_press)
  );

`ifdef MENU_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt_up;
  logic [REP_W-1:0] r_rep_cnt_dn;
  logic             r_rep_up;
  logic             r_rep_dn;

  // Repeat timers run only while a button is held in MENU; the press cycle
  // is count 0, so repeats land exactly REPEAT_CYCLES apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_cnt_up <= '0;
      r_rep_cnt_dn <= '0;
      r_rep_up     <= 1'b0;
      r_rep_dn     <= 1'b0;
    end else begin
      if (w_up_lvl && (r_state == MENU)) begin
        if (r_rep_cnt_up == REP_LAST) begin
          r_rep_cnt_up <= '0;
          r_rep_up     <= 1'b1;
        end else begin
          r_rep_cnt_up <= r_rep_cnt_up + REP_W'(1);
          r_rep_up     <= 1'b0;
        end
      end else begin
        r_rep_cnt_up <= '0;
        r_rep_up     <= 1'b0;
      end
      if (w_dn_lvl && (r_state == MENU)) begin
        if (r_rep_cnt_dn == REP_LAST) begin
          r_rep_cnt_dn <= '0;
          r_rep_dn     <= 1'b1;
        end else begin
          r_rep_cnt_dn <= r_rep_cnt_dn + REP_W'(1);
          r_rep_dn     <= 1'b0;
        end
      end else begin
        r_rep_cnt_dn <= '0;
        r_rep_dn     <= 1'b0;
      end
    end
  end

  // Merge initial presses with repeat pulses.
  always_comb begin
    w_up_evt = w_up_press | r_rep_up;
    w_dn_evt = w_dn_press | r_rep_dn;
    w_unused = &{1'b0, w_sel_lvl};
  end
`else
  // One event per press; the held levels are not needed.
  always_comb begin
    w_up_evt = w_up_press;
    w_dn_evt = w_dn_press;
    w_unused = &{1'b0, w_sel_lvl, w_up_lvl, w_dn_lvl, (REPEAT_CYCLES > 0)};
  end
`endif

  // Next-state, next-mode and start-pulse decode; sel wins over up/down.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_start_nxt = 1'b0;
    case (r_state)
      MENU: begin
        if (w_sel_press) begin
          w_state_nxt = PLAY;
          w_start_nxt = 1'b1;
        end else if (w_up_evt && !w_dn_evt) begin
          w_mode_nxt = mode_step(r_mode, 1'b1);
        end else if (w_dn_evt && !w_up_evt) begin
          w_mode_nxt = mode_step(r_mode, 1'b0);
        end else begin
          w_mode_nxt = r_mode;
        end
      end
      PLAY: begin
        if (game_over) begin
          w_state_nxt = OVER;
        end else begin
          w_state_nxt = PLAY;
        end
      end
      OVER: begin
        if (w_sel_press) begin
          w_state_nxt = MENU;
        end else begin
          w_state_nxt = OVER;
        end
      end
      default: begin
        w_state_nxt = MENU;
      end
    endcase
  end

  // State and registered outputs; in_menu/playing decode the next state so
  // they always match the state register and are mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= MENU;
      r_mode       <= '0;
      r_in_menu    <= 1'b1;
      r_playing    <= 1'b0;
      r_game_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_in_menu    <= (w_state_nxt == MENU);
      r_playing    <= (w_state_nxt == PLAY);
      r_game_start <= w_start_nxt;
    end
  end

  assign mode       = r_mode;
  assign in_menu    = r_in_menu;
  assign playing    = r_playing;
  assign game_start = r_game_start;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with DEB_CYCLES=4, REPEAT_CYCLES=16.
module tb_menu_ctrl;

  localparam int DEB = 4;
  localparam int REP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic       game_over;
  logic [2:0] mode;
  logic       in_menu;
  logic       playing;
  logic       game_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  menu_ctrl #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_sel    (btn_sel),
    .game_over  (game_over),
    .mode       (mode),
    .in_menu    (in_menu),
    .playing    (playing),
    .game_start (game_start)
  );

  typedef struct {
    string      name;
    logic       up;
    logic       dn;
    logic       sel;
    int         hold;
    logic [2:0] exp_mode;
    logic       exp_menu;
    logic       exp_play;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold the given raw buttons for 'hold' cycles, release, and let it settle.
  task automatic press(input logic up, input logic dn, input logic sel, input int hold);
    btn_up   = up;
    btn_down = dn;
    btn_sel  = sel;
    repeat (hold) tick();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_sel  = 1'b0;
    repeat (12) tick();
  endtask

  task automatic chk_state(input string name, input logic [2:0] m, input logic mn, input logic pl);
    chk({name, ".mode"}, {5'd0, mode}, {5'd0, m});
    chk({name, ".in_menu"}, {7'd0, in_menu}, {7'd0, mn});
    chk({name, ".playing"}, {7'd0, playing}, {7'd0, pl});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gs_cnt;
    int waited;
    logic [2:0] exp_rep;

    // name, up, dn, sel, hold, mode, in_menu, playing
    vecs[0]  = '{"glitch3",  1'b1, 1'b0, 1'b0, 3,  3'd0, 1'b1, 1'b0};
    vecs[1]  = '{"up_held",  1'b1, 1'b0, 1'b0, 10, 3'd1, 1'b1, 1'b0};
    vecs[2]  = '{"dn_1to0",  1'b0, 1'b1, 1'b0, 8,  3'd0, 1'b1, 1'b0};
    vecs[3]  = '{"dn_wrap",  1'b0, 1'b1, 1'b0, 8,  3'd7, 1'b1, 1'b0};
    vecs[4]  = '{"up_wrap0", 1'b1, 1'b0, 1'b0, 8,  3'd0, 1'b1, 1'b0};
    vecs[5]  = '{"up_1",     1'b1, 1'b0, 1'b0, 8,  3'd1, 1'b1, 1'b0};
    vecs[6]  = '{"up_2",     1'b1, 1'b0, 1'b0, 8,  3'd2, 1'b1, 1'b0};
    vecs[7]  = '{"up_3",     1'b1, 1'b0, 1'b0, 8,  3'd3, 1'b1, 1'b0};
    vecs[8]  = '{"up_4",     1'b1, 1'b0, 1'b0, 8,  3'd4, 1'b1, 1'b0};
    vecs[9]  = '{"up_5",     1'b1, 1'b0, 1'b0, 8,  3'd5, 1'b1, 1'b0};
    vecs[10] = '{"up_6",     1'b1, 1'b0, 1'b0, 8,  3'd6, 1'b1, 1'b0};
    vecs[11] = '{"up_7",     1'b1, 1'b0, 1'b0, 8,  3'd7, 1'b1, 1'b0};
    vecs[12] = '{"up_dn",    1'b1, 1'b1, 1'b0, 8,  3'd7, 1'b1, 1'b0};

    reset     = 1'b1;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_sel   = 1'b0;
    game_over = 1'b0;
    repeat (3) tick();
    chk_state("reset", 3'd0, 1'b1, 1'b0);
    chk("reset.game_start", {7'd0, game_start}, 8'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      press(vecs[i].up, vecs[i].dn, vecs[i].sel, vecs[i].hold);
      chk_state(vecs[i].name, vecs[i].exp_mode, vecs[i].exp_menu, vecs[i].exp_play);
    end

    // sel together with up: sel wins, single game_start pulse, mode kept.
    gs_cnt  = 0;
    btn_sel = 1'b1;
    btn_up  = 1'b1;
    repeat (16) begin
      tick();
      if (game_start === 1'b1) begin
        gs_cnt++;
        chk("sel_up.playing_at_start", {7'd0, playing}, 8'd1);
      end
      chk("sel_up.exclusive", {7'd0, in_menu & playing}, 8'd0);
    end
    btn_sel = 1'b0;
    btn_up  = 1'b0;
    repeat (12) tick();
    chk("sel_up.start_pulses", gs_cnt[7:0], 8'd1);
    chk_state("sel_up", 3'd7, 1'b0, 1'b1);

    // Up is ignored during play.
    press(1'b1, 1'b0, 1'b0, 8);
    chk_state("play_up", 3'd7, 1'b0, 1'b1);

    // game_over moves to OVER on the next clock.
    game_over = 1'b1;
    tick();
    chk_state("over_next", 3'd7, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 8);
    chk_state("over_dn", 3'd7, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 8);
    chk_state("over_sel", 3'd7, 1'b1, 1'b0);
    game_over = 1'b0;

    // Reach mode 5, start a game, then reset mid-play.
    press(1'b0, 1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 1'b0, 8);
    chk_state("to5", 3'd5, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1, 8);
    chk_state("play5", 3'd5, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    chk_state("mid_reset", 3'd0, 1'b1, 1'b0);
    chk("mid_reset.game_start", {7'd0, game_start}, 8'd0);
    reset = 1'b0;
    tick();

    // Hold up for 50 cycles past the first step.
    btn_up = 1'b1;
    waited = 0;
    while ((mode !== 3'd1) && (waited < 20)) begin
      tick();
      waited++;
    end
    chk("hold.first_step_seen", {7'd0, (mode === 3'd1)}, 8'd1);
    repeat (50) tick();
    btn_up = 1'b0;
    repeat (12) tick();
`ifdef MENU_AUTOREPEAT_EN
    exp_rep = 3'd4;
`else
    exp_rep = 3'd1;
`endif
    chk_state("hold50", exp_rep, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/menu_ctrl.md
MENU_CTRL -- requirements
Module: menu_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning clocks a raw button must be stable before its debounced level changes (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000, meaning the auto-repeat hold interval (used only under MENU_AUTOREPEAT_EN).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port btn_up, input, 1, meaning the raw, asynchronous mode-increment button.
REQ-006 SHALL have port btn_down, input, 1, meaning the raw, asynchronous mode-decrement button.
REQ-007 SHALL have port btn_sel, input, 1, meaning the raw, asynchronous select/start button.
REQ-008 SHALL have port game_over, input, 1, meaning a level from the game core that is high when a match has ended.
REQ-009 SHALL have port mode, output, 3, meaning the selected game mode 0..7 that drives the menu screen renderer and the game core.
REQ-010 SHALL have port in_menu, output, 1, meaning high while the FSM is in MENU (selects the menu screen on VGA).
REQ-011 SHALL have port playing, output, 1, meaning high while the FSM is in PLAY.
REQ-012 SHALL have port game_start, output, 1, meaning a one-cycle pulse on the MENU->PLAY transition.

Function
REQ-013 SHALL pass each raw button through a 2-flop synchronizer and then a debouncer, so that debounced level = synchronized input only after DEB_CYCLES consecutive equal samples; any mismatch restarts the count.
REQ-014 SHALL generate a one-cycle press event on each 0->1 transition of a debounced level; release generates no event.
REQ-015 SHALL implement FSM states MENU, PLAY, and OVER, and all outputs SHALL be registered.
REQ-016 In MENU, an up event SHALL set mode to mode+1 mod 8 (7 wraps to 0) and a down event SHALL set mode to mode-1 mod 8 (0 wraps to 7), both on the clock following the event.
REQ-017 In MENU, simultaneous up and down events SHALL leave mode unchanged.
REQ-018 In MENU, a sel event SHALL move the FSM to PLAY and pulse game_start for exactly 1 cycle; if up or down occurs in the same cycle, sel SHALL win and mode SHALL be unchanged.
REQ-019 In PLAY, mode SHALL be frozen and up/down/sel events ignored; game_over=1 SHALL move the FSM to OVER on the next clock.
REQ-020 In OVER, a sel event SHALL return the FSM to MENU with mode retained; up and down events SHALL be ignored.
REQ-021 The outputs in_menu and playing SHALL decode the state and SHALL never both be 1.

Reset
REQ-022 Reset SHALL set state=MENU, mode=0, in_menu=1, playing=0, game_start=0, all debounce counters to 0, debounced levels to 0, and repeat counters to 0.
REQ-023 Reset SHALL override all events in the same cycle; a button held through reset SHALL produce a press event DEB_CYCLES+sync latency after reset is released.

Configuration
REQ-024 With MENU_AUTOREPEAT_EN defined, an up/down button held in MENU SHALL emit an additional event every REPEAT_CYCLES after the initial press, until release; the repeat counter SHALL clear on release or on leaving MENU.
REQ-025 Without MENU_AUTOREPEAT_EN, exactly one event per press SHALL be produced and no repeat counter logic SHALL be present.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (MENU=2'd0, PLAY=2'd1, OVER=2'd2), NUM_MODES=8, and MODE_W=3.
REQ-027 A sub-module btn_debounce (synchronizer + debounce counter + rising-edge event, parameter DEB_CYCLES) SHALL be instantiated three times.

Verification (DEB_CYCLES=4, REPEAT_CYCLES=16)
REQ-028 Bench SHALL check: reset, then up held 10 cycles -> mode goes 0->1 exactly once; 3-cycle glitch on up -> mode stays 0.
REQ-029 Bench SHALL check: down press from mode=0 -> mode=7; 8 up presses from 7 -> mode=7 again (wrap verified).
REQ-030 Bench SHALL check: up and down released together in MENU -> mode unchanged; sel with up same cycle -> PLAY, game_start high 1 cycle, mode unchanged.
REQ-031 Bench SHALL check: in PLAY, up presses -> mode frozen; game_over=1 -> OVER next cycle; sel -> MENU with mode retained, in_menu=1.
REQ-032 Bench SHALL check: reset asserted mid-PLAY with mode=5 -> next cycle state=MENU, mode=0, game_start=0.
REQ-033 Bench SHALL check, with MENU_AUTOREPEAT_EN defined, up held 50 cycles past debounce -> mode advances 1+3=4 steps; without the macro -> 1 step.
